pio_led_shifter: RTL and testbench
==================================

Name: pio_led_shifter

Overview:
- Downstream consumer of the parallel GPIO output register: serialises a latched GPIO word onto the board's shift-register LED chain.
- Signal set: serial clock, serial data, latch/output-enable, active-low clear.
- Upstream asserts `start` on the same cycle it writes the GPIO register; this block shifts the captured word MSB-first, then pulses the latch.
- Sits between the CPU-side peripheral register and the board LED pins.

Parameters:
- DATA_W, 16: bits per frame; legal range is ≥ 2.
- CLK_DIV, 4: `clk` cycles per half-period of `sclk`; legal range is ≥ 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to send `data_in`.
- data_in  input  DATA_W  word to serialise; sampled only when `start` is accepted.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame completes.
- sclk  output  1  serial shift clock; data is valid on its rising edge.
- sdat  output  1  serial data, MSB first.
- sen  output  1  latch/output-enable pulse after the last bit.
- sclr_n  output  1  active-low clear to the LED chain.

Behaviour:
- **Clock and reset.** One clock `clk` and one reset `rst`; reset is synchronous and active-high. On a posedge with `rst`=1, all of the following return to 0 and the state machine goes to IDLE:
  - outputs: `busy`, `done`, `sclk`, `sdat`, `sen`, `sclr_n`
  - internal: `pending`, shift register, divider counter, bit counter
- **Clear output.** `sclr_n` goes to 1 on the first posedge with `rst`=0 and stays 1.
- **Reset mid-frame.** The frame is aborted. No `sen` and no `done` are produced.
- **All outputs are registered.** There are no combinational paths from inputs to outputs.
- **States.** IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- **IDLE**
  - `sclk`=0, `sen`=0, `busy`=0.
  - Start condition: `start`=1 or `pending`=1.
  - On the start condition, at that edge:
    - shift register ← `data_in`, or the pending buffer if `pending`=1.
    - `sdat` ← that word's MSB.
    - `busy` ← 1; divider ← 0; bit counter ← 0; `pending` ← 0.
    - Go to SHIFT_LO.
  - If `start` and `pending` are both 1, `data_in` wins (newest data).
- **SHIFT_LO**
  - `sclk`=0 for exactly CLK_DIV cycles, then go to SHIFT_HI with `sclk` ← 1.
- **SHIFT_HI**
  - `sclk`=1 for exactly CLK_DIV cycles.
  - On exit, `sclk` ← 0 and the bit counter increments.
  - If the bit counter was DATA_W-1: go to LATCH and set `sen` ← 1.
  - Otherwise: shift the register left by 1, set `sdat` ← the new MSB, and go to SHIFT_LO.
- **LATCH**
  - `sen`=1 and `sclk`=0 for exactly CLK_DIV cycles.
  - On exit: `sen` ← 0, `busy` ← 0, `done` ← 1 for one cycle, `sdat` ← 0, go to IDLE.
- **Timing**
  - `busy` is high for exactly 2·DATA_W·CLK_DIV + CLK_DIV cycles.
  - `done` coincides with the first cycle after `busy` falls.
  - `sdat` is stable for the full `sclk` period around each rising edge.
- **Start while busy**
  - `data_in` is captured into the pending buffer and `pending` ← 1.
  - Later starts overwrite the buffer; the last one wins and only one pending frame is held.
  - The pending frame begins at the edge where `done`=1, so `busy` re-asserts one cycle after `done`.
- **Frame isolation.** Changes on `data_in` without an accepted start never affect the frame in flight.
- **Counter widths.** The divider and bit counters are sized from CLK_DIV and DATA_W and must not wrap inside a phase. With CLK_DIV=1, each phase lasts exactly 1 cycle.

Test Plan:
1. Reset, then DATA_W=16, CLK_DIV=2, pulse `start` with `data_in`=16'hA5C3 → on `sclk` rising edges, bits sampled from `sdat` read A5C3 MSB-first; `busy` high 66 cycles; `sen` high 2 cycles after the 16th rising edge; `done` high exactly 1 cycle; `sclr_n`=1.
2. Start 16'h00FF, then after 10 cycles start 16'h1111, then after 5 more cycles start 16'h1234 → the first frame shifts 00FF; `busy` drops 1 cycle (the `done` cycle); the second frame shifts 1234, never 1111; exactly two `done` pulses.
3. Assert `rst` during the 7th bit of a frame → on the next edge all outputs are 0 and state is IDLE; no `sen` or `done` pulse; a new start with 16'hFFFF then completes normally (16 ones, 66 busy cycles).
4. CLK_DIV=1, DATA_W=8, start with 8'h81 → `sclk` toggles every cycle; `busy` high 17 cycles; received byte is 8'h81.
5. Toggle `data_in` randomly every cycle while a frame of 16'h5A5A is in flight, without `start` → the received word is exactly 5A5A; no second frame.
6. `start` held high with `pending` set at the `done` edge, `data_in`=16'hBEEF, pending buffer=16'h1234 → the next frame shifts BEEF.

Source files
------------

// File: rtl/pio_led_shifter.sv
// Serialises a captured GPIO word MSB-first onto a shift-register LED chain,
// then pulses the latch enable. One frame may be queued while another is in flight.
module pio_led_shifter #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              sdat,
  output logic              sen,
  output logic              sclr_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] pend_buf;
  logic              pending;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              div_end;
  logic              queue_req;

  assign div_end   = (div_cnt == DIV_LAST);
  assign queue_req = start && (state != IDLE);

  // The shift register MSB is the serial data flop itself.
  assign sdat = shreg[DATA_W-1];

  // NOTE: pend_buf is only ever read when pending=1, so it carries no reset;
  // pending itself is reset and qualifies it.
  always_ff @(posedge clk) begin
    if (queue_req) pend_buf <= data_in;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      pending <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      sen     <= 1'b0;
      sclr_n  <= 1'b0;
    end else begin
      sclr_n <= 1'b1;
      done   <= 1'b0;
      if (queue_req) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start || pending) begin
            // Fresh data beats a queued frame when both are present.
            shreg   <= start ? data_in : pend_buf;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            pending <= 1'b0;
            state   <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          if (div_end) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SHIFT_HI: begin
          if (div_end) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              sen   <= 1'b1;
              state <= LATCH;
            end else begin
              shreg <= {shreg[DATA_W-2:0], 1'b0};
              state <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        LATCH: begin
          if (div_end) begin
            div_cnt <= '0;
            sen     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            shreg   <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_led_shifter.sv
// Scoreboard bench for pio_led_shifter: a frame-timeline model predicts each
// frame's word and done cycle; a monitor decodes the serial pins and compares.
module tb_pio_led_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16, start16;
  logic [15:0] data16;
  logic        busy16, done16, sclk16, sdat16, sen16, sclr16;

  logic        rst8, start8;
  logic [7:0]  data8;
  logic        busy8, done8, sclk8, sdat8, sen8, sclr8;

  pio_led_shifter #(.DATA_W(16), .CLK_DIV(2)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .data_in(data16),
    .busy(busy16), .done(done16), .sclk(sclk16), .sdat(sdat16),
    .sen(sen16), .sclr_n(sclr16)
  );

  pio_led_shifter #(.DATA_W(8), .CLK_DIV(1)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .data_in(data8),
    .busy(busy8), .done(done8), .sclk(sclk8), .sdat(sdat8),
    .sen(sen8), .sclr_n(sclr8)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int wid(input int id);
    return (id == 0) ? 16 : 8;
  endfunction
  function automatic int div(input int id);
    return (id == 0) ? 2 : 1;
  endfunction
  function automatic int flen(input int id);
    return 2 * wid(id) * div(id) + div(id);
  endfunction

  typedef struct {
    logic [15:0] word;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  // Reference model: a frame occupies the link for flen cycles after the start
  // edge, done follows, and one most-recent request may wait behind it.
  int          cyc = 0;
  bit          m_inflight[2];
  int          m_end[2];
  bit          m_pend[2];
  logic [15:0] m_pword[2];

  task automatic model_step(input int id, input logic r, input logic s, input logic [15:0] d);
    exp_t e;
    if (r) begin
      if (m_inflight[id] && cyc <= m_end[id]) begin
        if (id == 0) void'(q0.pop_back()); else void'(q1.pop_back());
      end
      m_inflight[id] = 1'b0;
      m_pend[id]     = 1'b0;
      return;
    end
    if (m_inflight[id] && cyc > m_end[id]) m_inflight[id] = 1'b0;
    if (!m_inflight[id]) begin
      if (s || m_pend[id]) begin
        e.word         = s ? d : m_pword[id];
        e.cyc          = cyc + flen(id);
        m_inflight[id] = 1'b1;
        m_end[id]      = e.cyc;
        m_pend[id]     = 1'b0;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
      end
    end else if (s) begin
      m_pend[id]  = 1'b1;
      m_pword[id] = d;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, rst16, start16, data16);
    model_step(1, rst8, start8, {8'h00, data8});
  end

  // Monitor: decode bits on sclk rising edges, measure busy/sen, compare at done.
  bit          mon_prev[2];
  logic [15:0] mon_bits[2];
  int          mon_nbits[2];
  int          mon_busy[2];
  int          mon_sen[2];

  task automatic mon_clear(input int id);
    mon_prev[id]  = 1'b0;
    mon_bits[id]  = '0;
    mon_nbits[id] = 0;
    mon_busy[id]  = 0;
    mon_sen[id]   = 0;
  endtask

  task automatic mon_step(input int id, input logic r, input logic b, input logic dn,
                          input logic sc, input logic sd, input logic se, input logic cl);
    exp_t        e;
    logic [15:0] mask;
    string       tag;
    tag  = (id == 0) ? "d16" : "d8";
    mask = (id == 0) ? 16'hFFFF : 16'h00FF;
    if (r) begin
      mon_clear(id);
      return;
    end
    if (sc && !mon_prev[id]) begin
      mon_bits[id] = {mon_bits[id][14:0], sd};
      mon_nbits[id]++;
    end
    mon_prev[id] = sc;
    if (b)  mon_busy[id]++;
    if (se) mon_sen[id]++;
    if (dn) begin
      if (qsize(id) == 0) begin
        check({tag, " unexpected done"}, 32'(dn), 32'd0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        check({tag, " word"},       32'(mon_bits[id] & mask), 32'(e.word & mask));
        check({tag, " done cycle"}, 32'(cyc),                 32'(e.cyc));
        check({tag, " busy len"},   32'(mon_busy[id]),        32'(flen(id)));
        check({tag, " sen len"},    32'(mon_sen[id]),         32'(div(id)));
        check({tag, " bit count"},  32'(mon_nbits[id]),       32'(wid(id)));
        check({tag, " sclr_n"},     32'(cl),                  32'd1);
      end
      mon_clear(id);
    end
  endtask

  initial begin
    mon_clear(0);
    mon_clear(1);
  end

  always @(posedge clk) begin
    #1;
    mon_step(0, rst16, busy16, done16, sclk16, sdat16, sen16, sclr16);
    mon_step(1, rst8,  busy8,  done8,  sclk8,  sdat8,  sen8,  sclr8);
  end

  task automatic send16(input logic [15:0] w);
    start16 = 1'b1;
    data16  = w;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] w);
    start8 = 1'b1;
    data8  = w;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    for (int i = 0; i < 3000; i++) begin
      if (qsize(id) == 0 && !m_pend[id] && (!m_inflight[id] || cyc > m_end[id])) break;
      @(negedge clk);
    end
    check((id == 0) ? "d16 drained" : "d8 drained", 32'(qsize(id)), 32'd0);
  endtask

  initial begin
    rst16 = 1'b1; rst8 = 1'b1;
    start16 = 1'b0; start8 = 1'b0;
    data16 = '0; data8 = '0;
    repeat (3) @(negedge clk);
    check("d16 reset outputs", 32'({busy16, done16, sclk16, sdat16, sen16, sclr16}), 32'd0);
    check("d8 reset outputs",  32'({busy8, done8, sclk8, sdat8, sen8, sclr8}), 32'd0);
    rst16 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    check("d16 sclr_n after reset", 32'(sclr16), 32'd1);
    check("d8 sclr_n after reset",  32'(sclr8), 32'd1);

    // Single frame.
    send16(16'hA5C3);
    wait_idle(0);

    // Queued requests: the newest pending word replaces the older one.
    send16(16'h00FF);
    repeat (9) @(negedge clk);
    send16(16'h1111);
    repeat (4) @(negedge clk);
    send16(16'h1234);
    wait_idle(0);

    // Reset during the 7th bit aborts the frame without sen/done.
    send16(16'hC3C3);
    repeat (25) @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    check("d16 mid-frame reset outputs",
          32'({busy16, done16, sclk16, sdat16, sen16, sclr16}), 32'd0);
    rst16 = 1'b0;
    @(negedge clk);
    send16(16'hFFFF);
    wait_idle(0);

    // data_in noise without start must not disturb the frame.
    send16(16'h5A5A);
    for (int i = 0; i < 70; i++) begin
      data16 = 16'($urandom);
      @(negedge clk);
    end
    wait_idle(0);

    // start on the done cycle with a pending word: data_in wins.
    send16(16'h0F0F);
    repeat (5) @(negedge clk);
    send16(16'h1234);
    for (int i = 0; i < 200; i++) begin
      if (done16) break;
      @(negedge clk);
    end
    check("d16 done seen for handoff", 32'(done16), 32'd1);
    start16 = 1'b1;
    data16  = 16'hBEEF;
    @(negedge clk);
    start16 = 1'b0;
    wait_idle(0);

    // Fastest divider, byte frames.
    send8(8'h81);
    wait_idle(1);

    // Random traffic on both instances, including requests while busy.
    for (int i = 0; i < 800; i++) begin
      start16 = ($urandom_range(0, 29) == 0);
      data16  = 16'($urandom);
      start8  = ($urandom_range(0, 9) == 0);
      data8   = 8'($urandom);
      @(negedge clk);
    end
    start16 = 1'b0;
    start8  = 1'b0;
    wait_idle(0);
    wait_idle(1);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
